arith_seq_divider: RTL



---
 rtl/arith_seq_divider_pkg.sv | 65 ++++++
 rtl/arith_seq_divider_step.sv | 23 ++
 rtl/arith_seq_divider.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/arith_seq_divider_pkg.sv
// rtl/arith_seq_divider_pkg.sv - shared ALU operation, divider state and flag definitions
package ALUOperations;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REM  = 4'd12,
    ALU_REMU = 4'd13
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  localparam int DIV_LATENCY = 34;

  localparam int FLAG_C    = 0;
  localparam int FLAG_ODD  = 1;
  localparam int FLAG_EVEN = 2;
  localparam int FLAG_OV   = 3;
  localparam int FLAG_NEG  = 4;
  localparam int FLAG_ZERO = 5;
  localparam int FLAG_DBZ  = 6;

  function automatic logic isDivOp(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic isSignedOp(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic isRemOp(alu_op_t op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Same flag layout as the combinational arithmetic path.
  function automatic logic [6:0] makeFlags(logic [31:0] res, logic dbz, logic ov);
    logic [6:0] f;
    f            = '0;
    f[FLAG_C]    = 1'b0;
    f[FLAG_ODD]  = ^res;
    f[FLAG_EVEN] = ~^res;
    f[FLAG_OV]   = ov;
    f[FLAG_NEG]  = res[31];
    f[FLAG_ZERO] = (res == 32'd0);
    f[FLAG_DBZ]  = dbz;
    return f;
  endfunction

endpackage

// File: rtl/arith_seq_divider_step.sv
// rtl/arith_seq_divider_step.sv - one combinational restoring shift-subtract step
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] partRem,
  input  logic            dividendBit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] nextRem,
  output logic            quotBit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial-subtract the divisor; keep the difference only when it does not borrow.
  always_comb begin
    shifted = {partRem, dividendBit};
    diff    = shifted - {1'b0, divisor};
    quotBit = ~diff[XLEN];
    nextRem = quotBit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/arith_seq_divider.sv
// rtl/arith_seq_divider.sv - multi-cycle radix-2 DIV/DIVU/REM/REMU unit
module arith_seq_divider
  import ALUOperations::*;
#(
  parameter int XLEN      = 32,
  parameter int FAST_ZERO = 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            reqValid,
  output logic            reqReady,
  input  alu_op_t         aluOp,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            abort,
  output logic            rspValid,
  input  logic            rspReady,
  output logic [XLEN-1:0] result,
  output logic [6:0]      flags,
  output logic            busy
);

  div_state_t      state, stateNext;
  alu_op_t         opReg;
  logic [XLEN-1:0] aReg, bReg, remReg, resultReg;
  logic [6:0]      flagsReg;
  logic [4:0]      stepCnt;
  logic            negQ, negR, bZero, ovCase;
  logic [XLEN-1:0] stepRem;
  logic            stepQ;

  logic            signedOp, rawBZero, rawOv, fastCase;
  logic [XLEN-1:0] fastResult, quotS, remS, fixResult;

  div_restoring_step #(.XLEN(XLEN)) uStep (
    .partRem     (remReg),
    .dividendBit (aReg[XLEN-1]),
    .divisor     (bReg),
    .nextRem     (stepRem),
    .quotBit     (stepQ)
  );

  // Operand classification (valid in PREP, while aReg/bReg still hold raw operands) and FIX result.
  always_comb begin
    signedOp   = isSignedOp(opReg);
    rawBZero   = (bReg == '0);
    rawOv      = signedOp && (aReg == {1'b1, {(XLEN-1){1'b0}}}) && (bReg == '1);
    fastCase   = !isDivOp(opReg) || ((FAST_ZERO != 0) && (rawBZero || rawOv));
    fastResult = '0;
    if (rawOv && (opReg == ALU_DIV)) fastResult = aReg;
    quotS      = negQ ? -aReg : aReg;
    remS       = negR ? -remReg : remReg;
    fixResult  = bZero ? '0 : (isRemOp(opReg) ? remS : quotS);
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and handshake outputs; abort only cancels work that has not produced a response.
  always_comb begin
    stateNext = state;
    reqReady  = 1'b0;
    rspValid  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        busy     = 1'b0;
        if (reqValid) stateNext = PREP;
      end
      PREP: begin
        if (abort)         stateNext = IDLE;
        else if (fastCase) stateNext = DONE;
        else               stateNext = CALC;
      end
      CALC: begin
        if (abort)               stateNext = IDLE;
        else if (stepCnt == 5'd0) stateNext = FIX;
      end
      FIX: begin
        stateNext = abort ? IDLE : DONE;
      end
      DONE: begin
        rspValid = 1'b1;
        if (rspReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: latch operands, take magnitudes, iterate, then sign-fix into the result registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      opReg     <= ALU_ADD;
      aReg      <= '0;
      bReg      <= '0;
      remReg    <= '0;
      stepCnt   <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      bZero     <= 1'b0;
      ovCase    <= 1'b0;
      resultReg <= '0;
      flagsReg  <= '0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          opReg <= aluOp;
          aReg  <= opA;
          bReg  <= opB;
        end
        PREP: begin
          negQ    <= signedOp && (aReg[XLEN-1] ^ bReg[XLEN-1]);
          negR    <= signedOp && aReg[XLEN-1];
          aReg    <= (signedOp && aReg[XLEN-1]) ? -aReg : aReg;
          bReg    <= (signedOp && bReg[XLEN-1]) ? -bReg : bReg;
          remReg  <= '0;
          stepCnt <= 5'd31;
          bZero   <= rawBZero;
          ovCase  <= rawOv;
          if (fastCase) begin
            resultReg <= fastResult;
            flagsReg  <= makeFlags(fastResult, isDivOp(opReg) && rawBZero, rawOv);
          end
        end
        CALC: begin
          remReg  <= stepRem;
          aReg    <= {aReg[XLEN-2:0], stepQ};
          stepCnt <= stepCnt - 5'd1;
        end
        FIX: begin
          resultReg <= fixResult;
          flagsReg  <= makeFlags(fixResult, bZero, ovCase);
        end
        default: ;
      endcase
    end
  end

  assign result = resultReg;
  assign flags  = flagsReg;

endmodule
